// File: rtl/display_scanner.sv
// Multiplexed common-anode 7-segment scanner: prescaled digit scan, hex decode, dead time, leading-zero blanking, per-frame snapshot.
// Latency: all outputs registered, one cycle behind the scan counters and snapshot.
// Backpressure: none; EN low holds the scan at digit 0 and darkens the display from the next edge.
module display_scanner #(
  parameter int NUM_DIGITS  = 3,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [4*NUM_DIGITS-1:0]       DATA,
  input  logic [NUM_DIGITS-1:0]         DP_IN,
  input  logic [NUM_DIGITS-1:0]         BLANK_MASK,
  input  logic                          LZ_SUPPRESS,
  output logic [NUM_DIGITS-1:0]         DIGIT_EN,
  output logic [6:0]                    SEG,
  output logic                          DP,
  output logic [$clog2(NUM_DIGITS)-1:0] DIGIT_IDX,
  output logic                          FRAME_TICK
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  // scan state
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;

  // frame snapshot: display content only changes at frame boundaries
  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_lz;

  logic                    cnt_last;
  logic                    idx_last;
  logic                    frame_end;
  logic                    in_dead;
  logic [NUM_DIGITS-1:0]   lz_sup;
  logic                    dark;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   nxt_digit_en;
  logic [6:0]              nxt_seg;
  logic                    nxt_dp;

  // hex to active-low gfedcba
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign cnt_last  = (cnt == CW'(SCAN_DIV - 1));
  assign idx_last  = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end = cnt_last && idx_last;

  // dead window at the head of each slot; with no dead time the comparison would be constant
  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CW'(DEAD_CYCLES));
    end
  endgenerate

  // leading-zero map: digit i blanks when it and every more significant nibble are zero (digit 0 always shows)
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (snap_data[4*i +: 4] == 4'h0);
      lz_sup[i] = zero_run & snap_lz & (i != 0);
    end
  end

  // next output values for the slot currently being counted
  always_comb begin
    nibble       = snap_data[{idx, 2'b00} +: 4];
    dark         = in_dead | snap_blank[idx] | lz_sup[idx];
    nxt_digit_en = '1;
    nxt_seg      = 7'h7F;
    nxt_dp       = 1'b1;
    if (!dark) begin
      nxt_digit_en[idx] = 1'b0;
      nxt_seg           = hex7(nibble);
      nxt_dp            = ~snap_dp[idx];
    end
  end

  // scan counters, snapshot capture and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
      DIGIT_EN   <= '1;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      DIGIT_IDX  <= '0;
      FRAME_TICK <= 1'b0;
    end else if (!EN) begin
      // disabled: hold scan at the first slot and track inputs so the first frame is fresh
      cnt        <= '0;
      idx        <= '0;
      snap_data  <= DATA;
      snap_dp    <= DP_IN;
      snap_blank <= BLANK_MASK;
      snap_lz    <= LZ_SUPPRESS;
      DIGIT_EN   <= '1;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      DIGIT_IDX  <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        snap_data  <= DATA;
        snap_dp    <= DP_IN;
        snap_blank <= BLANK_MASK;
        snap_lz    <= LZ_SUPPRESS;
      end
      DIGIT_EN   <= nxt_digit_en;
      SEG        <= nxt_seg;
      DP         <= nxt_dp;
      DIGIT_IDX  <= idx;
      FRAME_TICK <= frame_end;
    end
  end

endmodule
